// File: rtl/w_writeback_grf.sv
// W-stage write-back mux with load extraction, 32x32 register file and commit counter.
// Optional macro GRF_BYPASS_EN forwards the committing WDW to RD1/RD2 in the same cycle.
module w_writeback_grf (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWriteW,
   input  logic [1:0]  MemtoRegW,
   input  logic [2:0]  LoadopW,
   input  logic [31:0] RDW,
   input  logic [31:0] ALUoutW,
   input  logic [31:0] PC_4W,
   input  logic [4:0]  AwriteW,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   output logic [31:0] WDW,
   output logic [31:0] WB_count
);

   logic [31:0] grf_q [32];
   logic [31:0] wb_count_q, wb_count_d;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        commit;
   logic [31:0] stored1, stored2;

   assign commit = RegWriteW && (AwriteW != 5'd0);

   always_comb begin
      ld_byte = 8'h0;
      unique case (ALUoutW[1:0])
         2'd0: ld_byte = RDW[7:0];
         2'd1: ld_byte = RDW[15:8];
         2'd2: ld_byte = RDW[23:16];
         2'd3: ld_byte = RDW[31:24];
         default: ld_byte = RDW[7:0];
      endcase
      ld_half = ALUoutW[1] ? RDW[31:16] : RDW[15:0];
   end

   always_comb begin
      ld_data = RDW;
      case (LoadopW)
         3'b001:  ld_data = {24'h0, ld_byte};
         3'b010:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b011:  ld_data = {16'h0, ld_half};
         3'b100:  ld_data = {{16{ld_half[15]}}, ld_half};
         default: ld_data = RDW;
      endcase
   end

   always_comb begin
      WDW = 32'h0;
      unique case (MemtoRegW)
         2'b00: WDW = ALUoutW;
         2'b01: WDW = ld_data;
         2'b10: WDW = PC_4W + 32'd4;
         2'b11: WDW = 32'h0;
         default: WDW = 32'h0;
      endcase
   end

   assign wb_count_d = wb_count_q + 32'd1;

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grf_q      <= '{default: 32'h0};
         wb_count_q <= 32'h0;
      end else if (commit) begin
         grf_q[AwriteW] <= WDW;
         wb_count_q     <= wb_count_d;
      end
   end

   assign stored1 = (A1 == 5'd0) ? 32'h0 : grf_q[A1];
   assign stored2 = (A2 == 5'd0) ? 32'h0 : grf_q[A2];

`ifdef GRF_BYPASS_EN
   // No write happens while reset is high, so nothing is forwarded then either.
   assign RD1 = (commit && !reset && (A1 == AwriteW)) ? WDW : stored1;
   assign RD2 = (commit && !reset && (A2 == AwriteW)) ? WDW : stored2;
`else
   assign RD1 = stored1;
   assign RD2 = stored2;
`endif

   assign WB_count = wb_count_q;

endmodule

// File: tb/tb_w_writeback_grf.sv
// Scoreboard bench for w_writeback_grf: the driver queues expected outputs from a
// behavioural model, and a negedge monitor pops and compares them.
module tb_w_writeback_grf;

   logic        clk;
   logic        reset;
   logic        RegWriteW;
   logic [1:0]  MemtoRegW;
   logic [2:0]  LoadopW;
   logic [31:0] RDW, ALUoutW, PC_4W;
   logic [4:0]  AwriteW, A1, A2;
   logic [31:0] RD1, RD2, WDW, WB_count;

   w_writeback_grf dut (
      .clk       (clk),
      .reset     (reset),
      .RegWriteW (RegWriteW),
      .MemtoRegW (MemtoRegW),
      .LoadopW   (LoadopW),
      .RDW       (RDW),
      .ALUoutW   (ALUoutW),
      .PC_4W     (PC_4W),
      .AwriteW   (AwriteW),
      .A1        (A1),
      .A2        (A2),
      .RD1       (RD1),
      .RD2       (RD2),
      .WDW       (WDW),
      .WB_count  (WB_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       tag;
   } chk_t;

   chk_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_grf [32];
   logic [31:0] model_cnt;

   function automatic logic [31:0] ref_wd(input logic [1:0] mtr, input logic [2:0] lop,
                                          input logic [31:0] rdw, input logic [31:0] alu,
                                          input logic [31:0] pc4);
      logic [31:0] off, b, h, ld;
      off = alu % 4;
      b   = (rdw >> (8 * off)) % 256;
      h   = (rdw >> (16 * (off / 2))) % 65536;
      case (lop)
         3'd1:    ld = b;
         3'd2:    ld = (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'd3:    ld = h;
         3'd4:    ld = (h >= 32768) ? h + 32'hFFFF0000 : h;
         default: ld = rdw;
      endcase
      case (mtr)
         2'd0:    return alu;
         2'd1:    return ld;
         2'd2:    return pc4 + 32'd4;
         default: return 32'h0;
      endcase
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 32; i++) model_grf[i] = 32'h0;
      model_cnt = 32'h0;
   endfunction

   function automatic void push(input int kind, input logic [31:0] exp, input string tag);
      chk_t e;
      e.kind = kind;
      e.exp  = exp;
      e.tag  = tag;
      sb_q.push_back(e);
   endfunction

   // Called just after a rising edge: drive, queue expectations, cross the next edge.
   task automatic cycle(input logic we, input logic [1:0] mtr, input logic [2:0] lop,
                        input logic [31:0] rdw, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [4:0] aw, input logic [4:0] a1, input logic [4:0] a2,
                        input string tag);
      logic [31:0] wd, e1, e2;
      logic        commit;
      RegWriteW = we;  MemtoRegW = mtr; LoadopW = lop; RDW = rdw;
      ALUoutW   = alu; PC_4W     = pc4; AwriteW = aw;  A1  = a1;  A2 = a2;
      wd     = ref_wd(mtr, lop, rdw, alu, pc4);
      commit = we && (aw != 0);
      e1     = model_grf[a1];
      e2     = model_grf[a2];
`ifdef GRF_BYPASS_EN
      if (commit && !reset && a1 == aw) e1 = wd;
      if (commit && !reset && a2 == aw) e2 = wd;
`endif
      push(0, e1, {tag, ".rd1"});
      push(1, e2, {tag, ".rd2"});
      push(2, wd, {tag, ".wdw"});
      push(3, model_cnt, {tag, ".cnt"});
      @(posedge clk);
      if (!reset && commit) begin
         model_grf[aw] = wd;
         model_cnt     = model_cnt + 32'd1;
      end
      #1;
   endtask

   chk_t        mon_e;
   logic [31:0] mon_act;
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         case (mon_e.kind)
            0:       mon_act = RD1;
            1:       mon_act = RD2;
            2:       mon_act = WDW;
            default: mon_act = WB_count;
         endcase
         checks++;
         if (mon_act !== mon_e.exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", mon_e.tag, mon_act, mon_e.exp);
         end
      end
   end

   initial begin
      logic [4:0] aw, a1, a2;
      model_clear();
      reset = 1'b1;
      RegWriteW = 0; MemtoRegW = 0; LoadopW = 0; RDW = 0; ALUoutW = 0; PC_4W = 0;
      AwriteW = 0; A1 = 0; A2 = 0;
      @(posedge clk); #1;
      // A commit attempted under reset must leave no trace.
      cycle(1, 2'd0, 3'd0, 0, 32'h77, 0, 5'd7, 5'd7, 5'd1, "rst");
      reset = 1'b0;
      cycle(0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd7, 5'd0, "rst_chk");

      cycle(0, 2'd1, 3'b010, 32'h80FF7F01, 32'h2, 0, 5'd0, 5'd0, 5'd0, "lb");
      cycle(0, 2'd1, 3'b100, 32'h80FF7F01, 32'h2, 0, 5'd0, 5'd0, 5'd0, "lh");
      cycle(0, 2'd1, 3'b011, 32'h80FF7F01, 32'h2, 0, 5'd0, 5'd0, 5'd0, "lhu");

      cycle(1, 2'd2, 3'd0, 0, 0, 32'h00003004, 5'd31, 5'd31, 5'd0, "link");
      cycle(0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd31, 5'd31, "link_chk");

      cycle(1, 2'd0, 3'd0, 0, 32'h0000DEAD, 0, 5'd0, 5'd0, 5'd0, "r0");
      cycle(1, 2'd0, 3'd0, 0, 32'h00000333, 0, 5'd3, 5'd0, 5'd3, "r3");
      cycle(0, 2'd0, 3'd0, 0, 32'h00000444, 0, 5'd3, 5'd0, 5'd3, "r3_nowe");
      cycle(0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd3, 5'd0, "r3_chk");

      cycle(1, 2'd0, 3'd0, 0, 32'h11111111, 0, 5'd8, 5'd0, 5'd0, "r8_old");
      cycle(1, 2'd0, 3'd0, 0, 32'hA5A5A5A5, 0, 5'd8, 5'd8, 5'd8, "r8_same");
      cycle(0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd8, 5'd8, "r8_chk");

      for (int n = 0; n < 300; n++) begin
         aw = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
         cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               $urandom, $urandom, $urandom, aw, a1, a2, "rand");
      end

      // Counter wrap: preload via force, then one commit.
      force dut.wb_count_q = 32'hFFFFFFFF;
      #1;
      release dut.wb_count_q;
      model_cnt = 32'hFFFFFFFF;
      cycle(1, 2'd0, 3'd0, 0, 32'h5, 0, 5'd9, 5'd0, 5'd0, "wrap");
      cycle(0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd9, 5'd0, "wrap_chk");

      // Mid-run reset clears $5 and the counter without a clock edge.
      cycle(1, 2'd0, 3'd0, 0, 32'h1234, 0, 5'd5, 5'd0, 5'd0, "r5");
      cycle(0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd5, 5'd0, "r5_chk");
      reset = 1'b1;
      model_clear();
      cycle(1, 2'd0, 3'd0, 0, 32'h9999, 0, 5'd5, 5'd5, 5'd5, "midrst");
      reset = 1'b0;
      cycle(0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd5, 5'd9, "midrst_chk");
      cycle(1, 2'd0, 3'd0, 0, 32'h42, 0, 5'd6, 5'd0, 5'd0, "post_rst");
      cycle(0, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd6, 5'd5, "post_rst_chk");

      @(negedge clk); #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
